// File: rtl/bcd_tc_decoder_pkg.sv
// Shared constants and FSM state type for the ten's-complement BCD decoder.
package bcd_tc_decoder_pkg;
    localparam int NUM_DIGITS = 7;
    localparam int DIGIT_W    = 4;
    localparam int WORD_W     = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return (d > 4'd9);
    endfunction
endpackage

// File: rtl/bcd_tc_decoder_digit_comp.sv
// Single-digit combinational unit: copies, ten's-complements or nine's-complements
// one BCD digit depending on sign and whether all lower digits were zero.
module bcd_digit_comp
    import bcd_tc_decoder_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               negate,
    input  logic               zero_run,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               zero_run_next,
    output logic               digit_err
);

    // Per-digit conversion rule
    always_comb begin
        out_digit     = 4'd0;
        zero_run_next = zero_run;
        digit_err     = 1'b0;
        if (digit_invalid(digit)) begin
            out_digit     = 4'd0;
            zero_run_next = 1'b0;
            digit_err     = 1'b1;
        end else if (!negate) begin
            out_digit     = digit;
            zero_run_next = zero_run;
        end else if (zero_run) begin
            if (digit == 4'd0) begin
                out_digit     = 4'd0;
                zero_run_next = 1'b1;
            end else begin
                out_digit     = 4'd10 - digit;
                zero_run_next = 1'b0;
            end
        end else begin
            out_digit     = 4'd9 - digit;
            zero_run_next = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_tc_decoder.sv
// Converts a 7-digit ten's-complement BCD subtraction result into sign/magnitude,
// one digit per cycle, LSD first, with a valid/ready handshake on each side.
module bcd_tc_decoder
    import bcd_tc_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] operand,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] magnitude,
    output logic              sign,
    output logic              bcd_err
);

    state_t              state_r, state_next_s;
    logic [IDX_W-1:0]    idx_r;
    logic [WORD_W-1:0]   opnd_r;
    logic [WORD_W-1:0]   res_r;
    logic                neg_r;
    logic                zrun_r;
    logic                err_r;
    logic                sign_r;
    logic [DIGIT_W-1:0]  dig_out_s;
    logic                zrun_next_s;
    logic                dig_err_s;
    logic                last_digit_s;
    logic [WORD_W-1:0]   res_next_s;

    bcd_digit_comp u_digit (
        .digit         (opnd_r[DIGIT_W-1:0]),
        .negate        (neg_r),
        .zero_run      (zrun_r),
        .out_digit     (dig_out_s),
        .zero_run_next (zrun_next_s),
        .digit_err     (dig_err_s)
    );

    assign last_digit_s = (idx_r == IDX_W'(NUM_DIGITS - 1));
    // Result fills from the top so the LSD lands at bits [3:0] after the last shift.
    assign res_next_s   = {dig_out_s, res_r[WORD_W-1:DIGIT_W]};

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign magnitude = res_r;
    assign sign      = sign_r;
    assign bcd_err   = err_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = CONV;
                else          state_next_s = IDLE;
            end
            CONV: begin
                if (last_digit_s) state_next_s = DONE;
                else              state_next_s = CONV;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand/result shift registers and per-transaction flags
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r  <= '0;
            opnd_r <= '0;
            res_r  <= '0;
            neg_r  <= 1'b0;
            zrun_r <= 1'b0;
            err_r  <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        idx_r  <= '0;
                        opnd_r <= operand;
                        res_r  <= '0;
                        neg_r  <= ~carry_in;
                        zrun_r <= 1'b1;
                        err_r  <= 1'b0;
                        sign_r <= 1'b0;
                    end
                end
                CONV: begin
                    idx_r  <= idx_r + 3'd1;
                    opnd_r <= opnd_r >> DIGIT_W;
                    res_r  <= res_next_s;
                    zrun_r <= zrun_next_s;
                    err_r  <= err_r | dig_err_s;
                    // No negative zero: sign only survives a non-zero magnitude.
                    if (last_digit_s) sign_r <= neg_r & (res_next_s != '0);
                end
                DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_tc_decoder.sv
// Self-checking bench: directed cases plus random operands checked against an
// arithmetic ten's-complement reference model.
module tb_bcd_tc_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] operand;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] magnitude;
    logic        sign;
    logic        bcd_err;

    int vectors = 0;
    int miscompares = 0;

    bcd_tc_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .sign      (sign),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal arithmetic when digits are valid, digit rules otherwise.
    task automatic ref_model(input logic [27:0] op, input logic ci,
                             output logic [27:0] mag, output logic sg, output logic er);
        int v, m, d;
        logic zr;
        er  = 1'b0;
        mag = '0;
        for (int i = 0; i < 7; i++) if (op[4*i +: 4] > 4'd9) er = 1'b1;
        if (!er) begin
            v = 0;
            for (int i = 6; i >= 0; i--) v = v * 10 + int'(op[4*i +: 4]);
            m = ci ? v : (10000000 - v) % 10000000;
            for (int i = 0; i < 7; i++) begin
                mag[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end else begin
            zr = 1'b1;
            for (int i = 0; i < 7; i++) begin
                d = int'(op[4*i +: 4]);
                if (d > 9) begin
                    mag[4*i +: 4] = 4'd0; zr = 1'b0;
                end else if (ci) begin
                    mag[4*i +: 4] = 4'(d);
                end else if (zr) begin
                    mag[4*i +: 4] = 4'((10 - d) % 10); zr = (d == 0);
                end else begin
                    mag[4*i +: 4] = 4'(9 - d);
                end
            end
        end
        sg = !ci && (mag != 28'd0);
    endtask

    // Starts and ends at a negedge.
    task automatic run_txn(input logic [27:0] op, input logic ci, input int stall);
        logic [27:0] emag;
        logic esg, eer;
        int n;
        ref_model(op, ci, emag, esg, eer);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("in_ready_before", 32'(in_ready), 32'd1);
        operand = op; carry_in = ci; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; operand = 28'($urandom); carry_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        check("latency", 32'(n), 32'd7);
        check("magnitude", 32'(magnitude), 32'(emag));
        check("sign", 32'(sign), 32'(esg));
        check("bcd_err", 32'(bcd_err), 32'(eer));
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            operand = 28'($urandom); in_valid = 1'b1;
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_mag", 32'(magnitude), 32'(emag));
            check("stall_sign", 32'(sign), 32'(esg));
            check("stall_err", 32'(bcd_err), 32'(eer));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [27:0] op;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; operand = '0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mag", 32'(magnitude), 32'd0);
        check("rst_sign", 32'(sign), 32'd0);
        check("rst_err", 32'(bcd_err), 32'd0);

        run_txn(28'h0001234, 1'b1, 0);
        run_txn(28'h9998766, 1'b0, 3);
        run_txn(28'h9999999, 1'b0, 0);
        run_txn(28'h9000000, 1'b0, 1);
        run_txn(28'h0000000, 1'b0, 0);
        run_txn(28'h00000A5, 1'b1, 0);
        run_txn(28'h0000000, 1'b1, 0);

        // Reset during the 4th conversion cycle.
        operand = 28'h1234567; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_mag", 32'(magnitude), 32'd0);
        check("midrst_sign", 32'(sign), 32'd0);
        check("midrst_err", 32'(bcd_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        run_txn(28'h9998766, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 7; i++)
                op[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) op[27:4] = '0;
            run_txn(op, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
